// File: rtl/lv163_counter4.sv
// lv163_counter4: a 74LV163-style synchronous binary counter that is WIDTH bits wide.
// Reset is asynchronous and active high. Clear and load are synchronous. CEP and CET
// enable counting. TC is the terminal-count output and is gated by CET, so several
// instances can be cascaded without ripple.
// Optional macro LV163_BUS_SWITCH_EN adds a tri-state output switch onto two buses,
// B1 and B2. Each bus has its own active-low enable.
module lv163_counter4 #(
    parameter int unsigned         WIDTH = 4,
    parameter logic [WIDTH-1:0]    INIT  = '0
) (
    input  logic             CP,
    input  logic             Reset,
    input  logic             MR_n,
    input  logic             PE_n,
    input  logic             CEP,
    input  logic             CET,
    input  logic [WIDTH-1:0] D,
`ifdef LV163_BUS_SWITCH_EN
    input  logic             OE1_n,
    input  logic             OE2_n,
    output tri   [WIDTH-1:0] B1,
    output tri   [WIDTH-1:0] B2,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_all_ones;

    // Next-state selection in pin priority order: clear, then load, then count, then hold
    always_comb begin
        w_q_next = r_q;
        if (!MR_n) begin
            w_q_next = '0;
        end else if (!PE_n) begin
            w_q_next = D;
        end else if (CEP && CET) begin
            w_q_next = r_q + ONE;
        end
    end

    // State register; asynchronous reset discards any pending load or increment
    always_ff @(posedge CP or posedge Reset) begin
        if (Reset) begin
            r_q <= INIT;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign w_all_ones = &r_q;
    assign Q          = r_q;
    // TC has no register stage: it uses the registered Q and the live CET, so a cascade can respond to it in the same cycle
    assign TC         = CET & w_all_ones;

`ifdef LV163_BUS_SWITCH_EN
    // The bus switch is combinational only and does not change Q or TC
    assign B1 = OE1_n ? {WIDTH{1'bz}} : r_q;
    assign B2 = OE2_n ? {WIDTH{1'bz}} : r_q;
`endif

endmodule

// File: tb/tb_lv163_counter4.sv
// Self-checking bench for lv163_counter4: directed test-plan cases, randomized
// control stimulus against an arithmetic reference model, and a three-stage cascade.
module tb_lv163_counter4;

    logic       CP = 1'b0;
    logic       Reset, MR_n, PE_n, CEP, CET;
    logic [3:0] D, Q;
    logic       TC;
    logic [4:0] D2, Q2;
    logic       TC2;
`ifdef LV163_BUS_SWITCH_EN
    logic       OE1_n, OE2_n;
    wire  [3:0] B1, B2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_q, m_q2, m_casc;

    always #5 CP = ~CP;

    lv163_counter4 #(.WIDTH(4), .INIT(4'h0)) dut (
        .CP(CP), .Reset(Reset), .MR_n(MR_n), .PE_n(PE_n), .CEP(CEP), .CET(CET), .D(D),
`ifdef LV163_BUS_SWITCH_EN
        .OE1_n(OE1_n), .OE2_n(OE2_n), .B1(B1), .B2(B2),
`endif
        .Q(Q), .TC(TC)
    );

    lv163_counter4 #(.WIDTH(5), .INIT(5'h1F)) dut2 (
        .CP(CP), .Reset(Reset), .MR_n(MR_n), .PE_n(PE_n), .CEP(CEP), .CET(CET), .D(D2),
`ifdef LV163_BUS_SWITCH_EN
        .OE1_n(1'b1), .OE2_n(1'b1), .B1(), .B2(),
`endif
        .Q(Q2), .TC(TC2)
    );

    logic       casc_rst, casc_en, casc_wrap, casc_mr_n;
    logic [3:0] cq0, cq1, cq2;
    logic       ctc0, ctc1, ctc2;

    assign casc_mr_n = !(casc_wrap && ({cq2, cq1, cq0} == 12'd799));

    lv163_counter4 #(.WIDTH(4), .INIT(4'h0)) c0 (
        .CP(CP), .Reset(casc_rst), .MR_n(casc_mr_n), .PE_n(1'b1), .CEP(casc_en), .CET(casc_en), .D(4'h0),
`ifdef LV163_BUS_SWITCH_EN
        .OE1_n(1'b1), .OE2_n(1'b1), .B1(), .B2(),
`endif
        .Q(cq0), .TC(ctc0)
    );
    lv163_counter4 #(.WIDTH(4), .INIT(4'h0)) c1 (
        .CP(CP), .Reset(casc_rst), .MR_n(casc_mr_n), .PE_n(1'b1), .CEP(ctc0), .CET(ctc0), .D(4'h0),
`ifdef LV163_BUS_SWITCH_EN
        .OE1_n(1'b1), .OE2_n(1'b1), .B1(), .B2(),
`endif
        .Q(cq1), .TC(ctc1)
    );
    lv163_counter4 #(.WIDTH(4), .INIT(4'h0)) c2 (
        .CP(CP), .Reset(casc_rst), .MR_n(casc_mr_n), .PE_n(1'b1), .CEP(ctc0), .CET(ctc1), .D(4'h0),
`ifdef LV163_BUS_SWITCH_EN
        .OE1_n(1'b1), .OE2_n(1'b1), .B1(), .B2(),
`endif
        .Q(cq2), .TC(ctc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the rules of the '163 applied to integers, modulo 2^w
    function automatic int ref_next(int q, int w, bit mr_n, bit pe_n, bit cep, bit cet, int d);
        if (!mr_n) return 0;
        if (!pe_n) return d % (1 << w);
        if (cep && cet) return (q + 1) % (1 << w);
        return q;
    endfunction

    function automatic bit ref_tc(int q, int w, bit cet);
        return cet && (q == (1 << w) - 1);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".Q"},   Q,   m_q);
        check({tag, ".TC"},  TC,  ref_tc(m_q, 4, CET));
        check({tag, ".Q2"},  Q2,  m_q2);
        check({tag, ".TC2"}, TC2, ref_tc(m_q2, 5, CET));
    endtask

    // Apply one clock edge with the current inputs, then check both counters
    task automatic step(input string tag);
        int nq, nq2;
        nq  = ref_next(m_q,  4, MR_n, PE_n, CEP, CET, D);
        nq2 = ref_next(m_q2, 5, MR_n, PE_n, CEP, CET, D2);
        @(posedge CP);
        #1;
        m_q  = nq;
        m_q2 = nq2;
        check_outputs(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        Reset = 1'b1;
        #2;
        m_q  = 0;
        m_q2 = 31;
        check_outputs(tag);
        Reset = 1'b0;
    endtask

    task automatic casc_step();
        @(posedge CP);
        #1;
        if (casc_wrap && m_casc == 799) m_casc = 0;
        else                            m_casc = (m_casc + 1) % 4096;
    endtask

    initial begin
        Reset = 1'b1; MR_n = 1'b1; PE_n = 1'b1; CEP = 1'b0; CET = 1'b1; D = '0; D2 = '0;
        casc_rst = 1'b1; casc_en = 1'b0; casc_wrap = 1'b0;
`ifdef LV163_BUS_SWITCH_EN
        OE1_n = 1'b1; OE2_n = 1'b1;
`endif
        m_q = 0; m_q2 = 31; m_casc = 0;
        #12;
        // During reset, TC follows INIT and the live CET
        check("rst.Q", Q, 4'h0);
        check("rst.TC", TC, 1'b0);
        check("rst.Q2", Q2, 5'h1F);
        check("rst.TC2_cet1", TC2, 1'b1);
        CET = 1'b0; #1;
        check("rst.TC2_cet0", TC2, 1'b0);
        Reset = 1'b0; casc_rst = 1'b0;
        #2;
        check("rst_release.Q", Q, 4'h0);

        // Reset pulse between edges with Q=9
        @(negedge CP);
        PE_n = 1'b0; D = 4'h9; D2 = 5'h09; CEP = 1'b1; CET = 1'b1;
        step("load9");
        PE_n = 1'b1;
        async_reset_pulse("midreset");
        for (int i = 0; i < 4; i++) step("count4");
        check("count4.final", Q, 4'h4);

        // Wrap and TC
        PE_n = 1'b0; D = 4'hE; D2 = 5'h1E;
        step("loadE");
        PE_n = 1'b1;
        step("toF");
        check("toF.TC", TC, 1'b1);
        CET = 1'b0; #1;
        check("cetdrop.TC", TC, 1'b0);
        check("cetdrop.Q", Q, 4'hF);
        step("holdF");
        CET = 1'b1;
        step("wrap0");
        check("wrap0.Q", Q, 4'h0);

        // Priority: clear beats load, load beats count, CEP=0 holds
        MR_n = 1'b0; PE_n = 1'b0; D = 4'h7; D2 = 5'h07; CEP = 1'b1; CET = 1'b1;
        step("prio_clr");
        MR_n = 1'b1;
        step("prio_load");
        PE_n = 1'b1; CEP = 1'b0;
        step("prio_hold");
        check("prio_hold.Q", Q, 4'h7);

`ifdef LV163_BUS_SWITCH_EN
        PE_n = 1'b0; D = 4'h5; D2 = 5'h05;
        step("load5");
        PE_n = 1'b1;
        OE1_n = 1'b0; OE2_n = 1'b1; #1;
        check("bus.B1_on", B1, 4'h5);
        check("bus.B2_off", B2, 4'bzzzz);
        OE1_n = 1'b1; OE2_n = 1'b0; #1;
        check("bus.B1_off", B1, 4'bzzzz);
        check("bus.B2_on", B2, 4'h5);
        OE1_n = 1'b0; #1;
        check("bus.both_B1", B1, 4'h5);
        check("bus.both_B2", B2, 4'h5);
        OE1_n = 1'b1; OE2_n = 1'b1; #1;
        check("bus.none_B1", B1, 4'bzzzz);
        check("bus.none_B2", B2, 4'bzzzz);
`endif

        // Randomized control patterns
        for (int i = 0; i < 400; i++) begin
            MR_n = ($urandom_range(0, 9) != 0);
            PE_n = ($urandom_range(0, 5) != 0);
            CEP  = ($urandom_range(0, 3) != 0);
            CET  = ($urandom_range(0, 3) != 0);
            D    = 4'($urandom);
            D2   = 5'($urandom);
            step("rand");
            if ($urandom_range(0, 29) == 0) async_reset_pulse("rand_rst");
        end

        // Cascade: twelve-bit column counter
        casc_rst = 1'b1; #1; casc_rst = 1'b0;
        m_casc = 0;
        check("casc.rst", {cq2, cq1, cq0}, 12'h000);
        casc_en = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            casc_step();
            if (i % 128 == 0) check("casc.run", {cq2, cq1, cq0}, m_casc);
            if (i == 256)     check("casc.256", {cq2, cq1, cq0}, 12'h100);
            if (i == 4095)    check("casc.tc2", ctc2, 1'b1);
        end
        check("casc.wrap", {cq2, cq1, cq0}, 12'h000);

        // Synchronous clear decoded from 799 gives a modulo-800 sequence
        casc_wrap = 1'b1;
        for (int i = 1; i <= 1601; i++) begin
            casc_step();
            if (i == 799 || i == 800 || i == 1599 || i == 1600 || i == 1601)
                check("casc.mod800", {cq2, cq1, cq0}, m_casc);
        end
        check("casc.1600", {cq2, cq1, cq0}, 12'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
